pattern_detector_mealy: RTL and testbench
=========================================

Name: pattern_detector_mealy

Overview:
Parametrised serial bit-pattern detector with a Mealy output. It compares a runtime-programmable PATTERN_W-bit pattern against the most recent PATTERN_W valid serial bits. A per-bit don't-care mask, overlap and non-overlap modes, and a saturating match counter are included. The block sits on a serial input stream and flags matches in the same cycle as the completing bit.

Parameters:
PATTERN_W, 2, pattern length in bits; legal range 2..32.
RESET_PATTERN, 'b01, pattern loaded at reset; bit PATTERN_W-1 is the first-received bit.
RESET_MASK, all ones, compare mask loaded at reset; 1 = compare, 0 = don't care.
RESET_OVERLAP, 1, overlap mode at reset.
CNT_W, 16, match counter width.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
cfg_load  in  1  load cfg_pattern, cfg_mask and cfg_overlap; restart detection
cfg_pattern  in  PATTERN_W  new pattern; MSB is compared against the oldest bit
cfg_mask  in  PATTERN_W  new compare mask
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
in_valid  in  1  a carries a stream bit this cycle
a  in  1  serial data bit
y  out  1  Mealy match flag; combinational from a, in_valid and state
armed  out  1  registered; fill has reached PATTERN_W-1
match_cnt  out  CNT_W  saturating count of y pulses
cnt_clr  in  1  synchronous clear of match_cnt

Behaviour:
- State registers:
  - pat_r, mask_r, ovl_r: configuration.
  - hist: PATTERN_W-1 bits, newest bit in hist[0].
  - fill: number of valid bits held since the last restart, saturating at PATTERN_W-1.
  - cnt: the match counter.
- Reset (async):
  - pat_r = RESET_PATTERN, mask_r = RESET_MASK, ovl_r = RESET_OVERLAP.
  - hist = 0, fill = 0, cnt = 0.
  - Outputs: y = 0, armed = 0, match_cnt = 0.
- Window: win = {hist, a}.
- match = in_valid & ~cfg_load & (fill == PATTERN_W-1) & (((win ^ pat_r) & mask_r) == 0).
- y = match; zero latency from the completing bit.
- in_valid = 0: no state change, y = 0.
- in_valid = 1 and no match: hist <= {hist[PATTERN_W-3:0], a}; fill <= min(fill+1, PATTERN_W-1).
- Match with ovl_r = 1: shift as above; fill stays PATTERN_W-1, so the next bit can complete a new match.
- Match with ovl_r = 0: hist <= 0 and fill <= 0 next cycle; none of the matched bits are reused.
- cfg_load = 1 has priority over in_valid:
  - pat_r, mask_r and ovl_r are loaded.
  - hist and fill are cleared.
  - The bit on a is discarded and y = 0 that cycle.
- mask_r = 0: every valid bit produces y once armed (fill == PATTERN_W-1).
- armed = (fill == PATTERN_W-1), registered.
- Counter: cnt_clr = 1 sets cnt <= 0, even if match is high that cycle. Otherwise match increments cnt, saturating at 2^CNT_W-1 with no wrap.
- Reset mid-stream: all partial matches are lost and configuration returns to the reset values.

Decomposition:
- Package pattern_det_pkg holds:
  - The mode constants (MODE_OVERLAP = 1, MODE_NON_OVERLAP = 0).
  - A function computing the masked compare.
- Sub-module sat_counter (parameter W; inputs inc and clr; output q) implements match_cnt and is reusable elsewhere.

Test Plan:
- Defaults after reset (W=2, pattern 01, overlap), stream a = 0,1,1,0,1 with in_valid = 1 -> y high on bits 1 and 4; match_cnt = 2.
- Load W=4, pattern 1011, mask 1111, overlap = 1; stream 1,0,1,1,0,1,1 -> y on bits 3 and 6. Reload with overlap = 0, same stream -> y on bit 3 only.
- Mask test: pattern 1001, mask 1011; streams 1,1,0,1 and 1,0,0,1 -> each gives y on its 4th bit. Stream 0,1,0,1 -> no y.
- in_valid gaps: insert idle cycles between bits of 1,0,1,1 -> y only in the cycle the final 1 is valid. y = 0 and hist is unchanged in idle cycles.
- cfg_load with in_valid = 1 on a completing bit -> y = 0, armed = 0 next cycle, and the bit is not counted.
- CNT_W = 2: five matches -> match_cnt = 3 (saturated). cnt_clr together with a match -> match_cnt = 0. Assert reset mid-pattern -> y = 0, armed = 0, and config returns to reset values.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// pattern_det_pkg: shared mode constants and masked compare helper for the pattern detector
package pattern_det_pkg;
  localparam logic MODE_OVERLAP     = 1'b1;
  localparam logic MODE_NON_OVERLAP = 1'b0;
  function automatic logic masked_eq(input logic [31:0] w, input logic [31:0] p, input logic [31:0] m);
    return ((w ^ p) & m) == '0;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  // count up to all-ones and hold there; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pattern_detector_mealy.sv
// pattern_detector_mealy: serial masked pattern detector with same-cycle Mealy match flag
module pattern_detector_mealy
  import pattern_det_pkg::*;
#(
  parameter int                   PATTERN_W     = 2,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = 'b01,
  parameter logic [PATTERN_W-1:0] RESET_MASK    = '1,
  parameter logic                 RESET_OVERLAP = 1'b1,
  parameter int                   CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic [PATTERN_W-1:0] cfg_mask,
  input  logic                 cfg_overlap,
  input  logic                 in_valid,
  input  logic                 a,
  output logic                 y,
  output logic                 armed,
  output logic [CNT_W-1:0]     match_cnt,
  input  logic                 cnt_clr
);
  localparam int             FW   = $clog2(PATTERN_W);
  localparam logic [FW-1:0]  FULL = FW'(PATTERN_W - 1);
  logic [PATTERN_W-1:0] pat_r, mask_r, win;
  logic [PATTERN_W-2:0] hist;
  logic [FW-1:0]        fill;
  logic                 ovl_r, full, match, restart;
  assign win     = {hist, a};
  assign full    = fill == FULL;
  assign match   = in_valid & ~cfg_load & full & masked_eq(32'(win), 32'(pat_r), 32'(mask_r));
  assign restart = match & (ovl_r == MODE_NON_OVERLAP);
  assign y       = match;
  assign armed   = full;
  // configuration load restarts detection; valid bits shift into history unless a non-overlapping match consumes them
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pat_r  <= RESET_PATTERN;
      mask_r <= RESET_MASK;
      ovl_r  <= RESET_OVERLAP;
      hist   <= '0;
      fill   <= '0;
    end else if (cfg_load) begin
      pat_r  <= cfg_pattern;
      mask_r <= cfg_mask;
      ovl_r  <= cfg_overlap;
      hist   <= '0;
      fill   <= '0;
    end else if (in_valid) begin
      hist <= restart ? '0 : win[PATTERN_W-2:0];
      fill <= restart ? '0 : full ? FULL : fill + 1'b1;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (cnt_clr),
    .q    (match_cnt)
  );
endmodule

// File: tb/tb_pattern_detector_mealy.sv
// tb_pattern_detector_mealy: directed plus random stimulus against a bit-list reference model
module tb_pattern_detector_mealy;
  logic clk = 1'b0;
  logic reset, cfg_load, cfg_overlap, in_valid, a, cnt_clr;
  logic [1:0] cp2, cm2;
  logic [3:0] cp4, cm4;
  logic y2, y4, armed2, armed4;
  logic [15:0] cnt2;
  logic [1:0] cnt4;
  int n_cmp = 0, n_err = 0;
  bit q2[$], q4[$];
  logic [31:0] mp2, mm2, mp4, mm4;
  bit mo2, mo4;
  int mc2, mc4;

  always #5 clk = ~clk;

  pattern_detector_mealy #(.PATTERN_W(2)) u2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cp2), .cfg_mask(cm2),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .a(a), .y(y2), .armed(armed2),
    .match_cnt(cnt2), .cnt_clr(cnt_clr)
  );

  pattern_detector_mealy #(.PATTERN_W(4), .RESET_PATTERN(4'b0110), .RESET_MASK(4'b1111),
    .RESET_OVERLAP(1'b0), .CNT_W(2)) u4 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cp4), .cfg_mask(cm4),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .a(a), .y(y4), .armed(armed4),
    .match_cnt(cnt4), .cnt_clr(cnt_clr)
  );

  // match if the last w-1 accepted bits plus the new bit agree with the pattern on every masked position
  function automatic bit exp_match(input bit q[$], input int w, input logic [31:0] pat,
                                   input logic [31:0] msk, input bit b);
    bit v;
    if (q.size() < w - 1) return 1'b0;
    for (int i = 0; i < w; i++) begin
      v = (i == 0) ? b : q[q.size() - i];
      if (msk[i] && v != pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mp2 = 32'b01;   mm2 = 32'b11;   mo2 = 1'b1;
    mp4 = 32'b0110; mm4 = 32'b1111; mo4 = 1'b0;
    q2.delete(); q4.delete();
    mc2 = 0; mc4 = 0;
  endtask

  task automatic step(input bit v, input bit b, input bit l = 1'b0, input bit clr = 1'b0);
    bit e2, e4;
    in_valid = v; a = b; cfg_load = l; cnt_clr = clr;
    #1;
    e2 = v && !l && exp_match(q2, 2, mp2, mm2, b);
    e4 = v && !l && exp_match(q4, 4, mp4, mm4, b);
    chk("y2", y2, e2);
    chk("y4", y4, e4);
    if (l) begin
      mp2 = cp2; mm2 = cm2; mo2 = cfg_overlap;
      mp4 = cp4; mm4 = cm4; mo4 = cfg_overlap;
      q2.delete(); q4.delete();
    end else if (v) begin
      if (e2 && !mo2) q2.delete(); else q2.push_back(b);
      if (e4 && !mo4) q4.delete(); else q4.push_back(b);
      if (q2.size() > 40) void'(q2.pop_front());
      if (q4.size() > 40) void'(q4.pop_front());
    end
    mc2 = clr ? 0 : (e2 && mc2 < 65535) ? mc2 + 1 : mc2;
    mc4 = clr ? 0 : (e4 && mc4 < 3) ? mc4 + 1 : mc4;
    @(posedge clk); #1;
    chk("armed2", armed2, q2.size() >= 1);
    chk("armed4", armed4, q4.size() >= 3);
    chk("cnt2", cnt2, mc2);
    chk("cnt4", cnt4, mc4);
  endtask

  task automatic load(input logic [1:0] p2, input logic [1:0] m2, input logic [3:0] p4,
                      input logic [3:0] m4, input bit o, input bit v = 1'b0, input bit b = 1'b0);
    cp2 = p2; cm2 = m2; cp4 = p4; cm4 = m4; cfg_overlap = o;
    step(v, b, 1'b1);
  endtask

  task automatic stream(input bit [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  initial begin
    reset = 1'b1; cfg_load = 0; cfg_overlap = 0; in_valid = 0; a = 0; cnt_clr = 0;
    cp2 = 0; cm2 = 0; cp4 = 0; cm4 = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_y2", y2, 0); chk("rst_armed2", armed2, 0); chk("rst_cnt2", cnt2, 0);
    chk("rst_armed4", armed4, 0); chk("rst_cnt4", cnt4, 0);
    // defaults: W=2 pattern 01 overlapping
    stream(16'b01101, 5);
    chk("default_cnt2", cnt2, 2);
    // W=4 pattern 1011, overlap then non-overlap
    load(2'b11, 2'b11, 4'b1011, 4'b1111, 1'b1);
    stream(16'b1011011, 7);
    load(2'b11, 2'b11, 4'b1011, 4'b1111, 1'b0);
    stream(16'b1011011, 7);
    // don't-care mask
    load(2'b10, 2'b01, 4'b1001, 4'b1011, 1'b1);
    stream(16'b1101, 4);
    load(2'b10, 2'b01, 4'b1001, 4'b1011, 1'b1);
    stream(16'b1001, 4);
    load(2'b10, 2'b01, 4'b1001, 4'b1011, 1'b1);
    stream(16'b0101, 4);
    // idle gaps between valid bits
    load(2'b01, 2'b11, 4'b1011, 4'b1111, 1'b1);
    step(1, 1); step(0, 0); step(0, 1); step(1, 0); step(0, 0);
    step(1, 1); step(0, 1); step(0, 0); step(1, 1); step(0, 1);
    // load on a completing bit discards it
    load(2'b01, 2'b11, 4'b1011, 4'b1111, 1'b1);
    stream(16'b101, 3);
    load(2'b01, 2'b11, 4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1);
    chk("load_armed4", armed4, 0);
    // saturation and clear-with-match
    step(0, 0, 0, 1);
    load(2'b00, 2'b00, 4'b0000, 4'b0000, 1'b1);
    stream(16'hff, 8);
    chk("sat_cnt4", cnt4, 3);
    step(1, 1, 0, 1);
    chk("clr_cnt4", cnt4, 0);
    // asynchronous reset mid-pattern
    load(2'b11, 2'b11, 4'b1011, 4'b1111, 1'b1);
    stream(16'b101, 3);
    in_valid = 1; a = 1;
    reset = 1'b1;
    #1;
    chk("midrst_y4", y4, 0); chk("midrst_armed4", armed4, 0); chk("midrst_cnt4", cnt4, 0);
    #1 reset = 1'b0;
    reset_model();
    stream(16'b0110, 4);
    chk("rstcfg_cnt4", cnt4, 1);
    chk("rstcfg_cnt2", cnt2, 1);
    // randomized traffic
    repeat (400) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) load(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
      else step(($urandom % 4) != 0, 1'($urandom), 1'b0, r == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
